branch_predict_unit: RTL

//  Parametrised successor to the combinational branch controller. Predicts next-fetch
//  PC at IF with a direct-mapped BTB plus 2-bit BHT. Resolves branches at EX using the

---
 rtl/branch_predict_unit.sv | 127 ++++++++++++
 1 files changed

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - BTB + 2-bit BHT next-PC predictor with EX-stage resolution and stats
module branch_predict_unit #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  f_pc,
  output logic             f_pred_taken,
  output logic [XLEN-1:0]  f_pred_target,
  input  logic             e_valid,
  input  logic [XLEN-1:0]  e_pc,
  input  logic [1:0]       e_bra_mode,
  input  logic             e_cmp_z,
  input  logic             e_cmp_inv,
  input  logic             e_alu_z,
  input  logic             e_alu_lsb,
  input  logic [XLEN-1:0]  e_src_alu,
  input  logic [XLEN-1:0]  e_src_imm,
  input  logic             e_pred_taken,
  input  logic [XLEN-1:0]  e_pred_target,
  output logic             e_redirect,
  output logic [XLEN-1:0]  e_redirect_addr,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispred
);

  localparam int IDX_W = $clog2(ENTRIES);

  typedef enum logic [1:0] {
    MODE_DIS = 2'b00,
    MODE_JMP = 2'b01,
    MODE_CMP = 2'b10,
    MODE_ALU = 2'b11
  } bra_mode_t;

  logic [ENTRIES-1:0] btb_valid;
  logic [ENTRIES-1:0] btb_uncond;
  logic [TAG_W-1:0]   btb_tag    [ENTRIES];
  logic [XLEN-1:0]    btb_target [ENTRIES];
  logic [1:0]         bht        [ENTRIES];

  logic [IDX_W-1:0] f_idx, e_idx;
  logic [TAG_W-1:0] f_tag, e_tag;
  logic             f_hit, e_hit;
  bra_mode_t        e_mode;
  logic             e_taken;
  logic [XLEN-1:0]  e_target;
  logic [XLEN-1:0]  e_actual_next;
  logic             btb_write, btb_evict, bht_train;
  logic             unused_alu_lsb;

  assign f_idx  = f_pc[IDX_W+1:2];
  assign f_tag  = f_pc[IDX_W+2 +: TAG_W];
  assign e_idx  = e_pc[IDX_W+1:2];
  assign e_tag  = e_pc[IDX_W+2 +: TAG_W];
  assign e_mode = bra_mode_t'(e_bra_mode);

  // Fetch-side lookup reads pre-update table contents; no EX->IF bypass.
  assign f_hit         = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
  assign f_pred_taken  = f_hit && (btb_uncond[f_idx] || bht[f_idx][1]);
  assign f_pred_target = f_pred_taken ? btb_target[f_idx] : f_pc + XLEN'(4);

  always_comb begin
    e_taken  = 1'b0;
    e_target = e_pc + e_src_imm;
    unique case (e_mode)
      MODE_JMP: e_taken = 1'b1;
      MODE_CMP: e_taken = (e_cmp_z ? e_alu_z : e_alu_lsb) ^ e_cmp_inv;
      MODE_ALU: begin
        e_taken  = 1'b1;
        e_target = {e_src_alu[XLEN-1:1], 1'b0};
      end
      default:  e_taken = 1'b0;
    endcase
  end

  // Only the full next-PC matters; e_pred_taken is redundant with the target compare.
  assign e_actual_next   = e_taken ? e_target : e_pc + XLEN'(4);
  assign e_redirect      = e_valid && (e_actual_next != e_pred_target);
  assign e_redirect_addr = e_actual_next;
  assign unused_alu_lsb  = e_src_alu[0] ^ e_pred_taken;

  assign e_hit     = btb_valid[e_idx] && (btb_tag[e_idx] == e_tag);
  assign btb_write = e_valid && ((e_mode == MODE_CMP && e_taken) ||
                                 e_mode == MODE_JMP || e_mode == MODE_ALU);
  assign btb_evict = e_valid && (e_mode == MODE_DIS) && e_hit;
  assign bht_train = e_valid && (e_mode == MODE_CMP);

  always_ff @(posedge clk) begin
    if (rst) begin
      btb_valid     <= '0;
      btb_uncond    <= '0;
      stat_branches <= '0;
      stat_mispred  <= '0;
      for (int k = 0; k < ENTRIES; k++) bht[k] <= 2'b01;
    end else begin
      if (btb_write) begin
        btb_valid[e_idx]  <= 1'b1;
        btb_uncond[e_idx] <= (e_mode != MODE_CMP);
      end else if (btb_evict) begin
        btb_valid[e_idx]  <= 1'b0;
      end
      if (bht_train) begin
        if (e_taken && bht[e_idx] != 2'b11)
          bht[e_idx] <= bht[e_idx] + 2'b01;
        else if (!e_taken && bht[e_idx] != 2'b00)
          bht[e_idx] <= bht[e_idx] - 2'b01;
      end
      if (e_valid && e_mode != MODE_DIS && stat_branches != '1)
        stat_branches <= stat_branches + CNT_W'(1);
      if (e_redirect && stat_mispred != '1)
        stat_mispred <= stat_mispred + CNT_W'(1);
    end
  end

  // Payload arrays need no reset; btb_valid guards them.
  always_ff @(posedge clk) begin
    if (!rst && btb_write) begin
      btb_tag[e_idx]    <= e_tag;
      btb_target[e_idx] <= e_target;
    end
  end

endmodule
